// File: rtl/wb_test_slave.sv
// rtl/wb_test_slave.sv - Wishbone classic-cycle word-memory responder with programmable wait states
module wb_test_slave #(
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        CYC,
    input  logic        STB,
    input  logic        WE,
    input  logic [31:0] ADR,
    input  logic [31:0] DAT_I,
    input  logic [2:0]  CTI_I,
    output logic [31:0] DAT_O,
    output logic        ACK,
    output logic        ERR,
    output logic        RTY
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [3:0]      cnt;
    logic [AW-1:0]   lat_adr;
    logic            lat_we;
    logic [31:0]     lat_dat;
    logic [31:0]     mem [DEPTH];

    logic            req;
    logic            illegal;
    logic            do_access;
    logic            do_err;
    logic [AW-1:0]   acc_adr;
    logic            acc_we;
    logic [31:0]     acc_dat;

    assign req     = CYC & STB;
    // Full-width address compare so high address bits never alias into the array.
    assign illegal = (ADR >= 32'(DEPTH)) || (CTI_I inside {[3'd3:3'd6]});

    // Retry is never issued.
    assign RTY = 1'b0;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state decode; RESP always returns to IDLE so a lingering STB is not a new request.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (req) begin
                    if (illegal || (WAIT_STATES == 0)) begin
                        state_nx = S_RESP;
                    end else begin
                        state_nx = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (!req) begin
                    state_nx = S_IDLE;
                end else if (cnt == 4'd0) begin
                    state_nx = S_RESP;
                end
            end
            S_RESP:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Decide whether this edge performs the memory access or an error termination, and with which operands.
    always_comb begin
        do_access = 1'b0;
        do_err    = 1'b0;
        acc_adr   = ADR[AW-1:0];
        acc_we    = WE;
        acc_dat   = DAT_I;
        case (state)
            S_IDLE: begin
                if (req) begin
                    if (illegal) begin
                        do_err = 1'b1;
                    end else if (WAIT_STATES == 0) begin
                        do_access = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                acc_adr = lat_adr;
                acc_we  = lat_we;
                acc_dat = lat_dat;
                if (req && (cnt == 4'd0)) begin
                    do_access = 1'b1;
                end
            end
            default: begin
                do_access = 1'b0;
                do_err    = 1'b0;
            end
        endcase
    end

    // Wait counter and request latch; operands are captured only when leaving IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt     <= 4'd0;
            lat_adr <= '0;
            lat_we  <= 1'b0;
            lat_dat <= 32'd0;
        end else begin
            if ((state == S_IDLE) && req) begin
                cnt     <= 4'(WAIT_STATES - 1);
                lat_adr <= ADR[AW-1:0];
                lat_we  <= WE;
                lat_dat <= DAT_I;
            end else if ((state == S_WAIT) && req && (cnt != 4'd0)) begin
                cnt <= cnt - 4'd1;
            end
        end
    end

    // Registered bus responses; DAT_O only changes on a completed read.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ACK   <= 1'b0;
            ERR   <= 1'b0;
            DAT_O <= 32'd0;
        end else begin
            ACK <= do_access;
            ERR <= do_err;
            if (do_access && !acc_we) begin
                DAT_O <= mem[acc_adr];
            end
        end
    end

    // Memory array is not reset so contents survive a mid-operation reset.
    always_ff @(posedge clk) begin
        if (rst && do_access && acc_we) begin
            mem[acc_adr] <= acc_dat;
        end
    end

endmodule
